// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant encoding
// and the latency counter width.
package mem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant (bit0 = I, bit1 = D)
// with a registered record of the last winner.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   grant_t last_grant;

   // On a tie, the port that did not win last time goes first.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == GNT_I) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         last_grant <= GNT_I;
      end else if (update && (gnt != 2'b00)) begin
         last_grant <= gnt[1] ? GNT_D : GNT_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single-port fixed-latency unified memory between the
// instruction-fetch and data ports using req/ack handshakes.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned LAT = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          IReq,
   input  logic [AW-1:0] IAddr,
   output logic          IAck,
   input  logic          DReq,
   input  logic          DWe,
   input  logic [AW-1:0] DAddr,
   input  logic [DW-1:0] DWdata,
   output logic          DAck,
   output logic [DW-1:0] RData,
   output logic [AW-1:0] MemAddr,
   output logic          MemWrite,
   output logic [DW-1:0] MemWdata,
   input  logic [DW-1:0] MemRdata,
   output logic          Busy
);

   if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: LAT must be within 1..15");
   end

   state_t           state;
   state_t           state_nx;
   grant_t           grant;
   logic             we;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       gnt;
   logic             start;
   logic             iack_nx;
   logic             dack_nx;
   logic             mem_write_nx;
   logic             busy_nx;

   assign start = (state == IDLE) && (IReq || DReq);

   rr_arb2 u_rr_arb2 (
      .Clk    (Clk),
      .Reset  (Reset),
      .req    ({DReq, IReq}),
      .update (start),
      .gnt    (gnt)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (IReq || DReq) state_nx = ACCESS;
         ACCESS:  state_nx = we ? RESP : WAIT;
         WAIT:    if (cnt == '0) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered handshake/strobe outputs.
   always_comb begin
      iack_nx      = 1'b0;
      dack_nx      = 1'b0;
      mem_write_nx = 1'b0;
      busy_nx      = (state_nx != IDLE);
      if (state_nx == RESP) begin
         iack_nx = (grant == GNT_I);
         dack_nx = (grant == GNT_D);
      end
      if (start && gnt[1]) begin
         mem_write_nx = DWe;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grant    <= GNT_I;
         we       <= 1'b0;
         cnt      <= '0;
         IAck     <= 1'b0;
         DAck     <= 1'b0;
         MemWrite <= 1'b0;
         Busy     <= 1'b0;
         MemAddr  <= '0;
         MemWdata <= '0;
         RData    <= '0;
      end else begin
         IAck     <= iack_nx;
         DAck     <= dack_nx;
         MemWrite <= mem_write_nx;
         Busy     <= busy_nx;
         if (start) begin
            grant   <= gnt[1] ? GNT_D : GNT_I;
            we      <= gnt[1] & DWe;
            MemAddr <= gnt[1] ? DAddr : IAddr;
            if (gnt[1]) begin
               MemWdata <= DWdata;
            end
         end
         if (state == ACCESS && !we) begin
            cnt <= CNT_W'(LAT - 1);
         end else if (state == WAIT) begin
            if (cnt == '0) begin
               RData <= MemRdata;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three builds (LAT = 2, 1, 15) each
// driven against a fixed-latency memory model.
module tb_mem_port_arbiter;

   typedef struct {
      bit          d;
      logic [31:0] data;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        ireq[3], dreq[3], dwe[3];
   logic [31:0] iaddr[3], daddr[3], dwdata[3];
   logic        iack[3], dack[3], mwrite[3], busy[3];
   logic [31:0] rdata[3], maddr[3], mwdata[3], mrdata[3];

   exp_t        sb[3][$];
   logic [31:0] last_rd[3];
   int          checks = 0;
   int          errors = 0;
   int          exp_c[3];
   bit          exp_d[3];

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'h8C22_0004;
         32'h0000_0008: return 32'h1234_5678;
         default:       return ~a ^ 32'hA5A5_0000;
      endcase
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic [31:0] pipe[15];

      mem_port_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
         .Clk      (Clk),
         .Reset    (Reset),
         .IReq     (ireq[g]),
         .IAddr    (iaddr[g]),
         .IAck     (iack[g]),
         .DReq     (dreq[g]),
         .DWe      (dwe[g]),
         .DAddr    (daddr[g]),
         .DWdata   (dwdata[g]),
         .DAck     (dack[g]),
         .RData    (rdata[g]),
         .MemAddr  (maddr[g]),
         .MemWrite (mwrite[g]),
         .MemWdata (mwdata[g]),
         .MemRdata (mrdata[g]),
         .Busy     (busy[g])
      );

      // Memory model: address sampled each edge, data appears L edges later.
      always @(posedge Clk) begin
         pipe[0] <= mem_word(maddr[g]);
         for (int i = 1; i < 15; i++) pipe[i] <= pipe[i-1];
      end
      assign mrdata[g] = pipe[L-1];

      // Scoreboard monitor: every ack pops one expected response.
      always @(negedge Clk) begin
         if (!Reset && (iack[g] || dack[g])) begin
            if (sb[g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack dut%0d: got i=%b d=%b, expected none", g, iack[g], dack[g]);
            end else begin
               exp_t e;
               e = sb[g].pop_front();
               chk($sformatf("ack_port dut%0d", g), 32'({iack[g], dack[g]}), 32'({~e.d, e.d}));
               chk($sformatf("rdata dut%0d", g), rdata[g], e.data);
            end
         end
      end
   end

   task automatic push_exp(input int g, input bit d, input bit we, input logic [31:0] addr);
      exp_t e;
      e.d = d;
      if (!we) last_rd[g] = mem_word(addr);
      e.data = last_rd[g];
      sb[g].push_back(e);
   endtask

   // One access: checks strobes/address per cycle and the ack cycle number.
   task automatic run_single(input int g, input bit d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at, input string name);
      int ack_c = -1;
      push_exp(g, d, we, addr);
      @(posedge Clk);
      #1;
      if (d) begin
         dreq[g] = 1'b1; dwe[g] = we; daddr[g] = addr; dwdata[g] = wdata;
      end else begin
         ireq[g] = 1'b1; iaddr[g] = addr;
      end
      for (int c = 0; c <= ack_at + 3 && ack_c < 0; c++) begin
         @(negedge Clk);
         chk({name, "_mwrite"}, 32'(mwrite[g]), 32'(we && c == 1));
         if (c == 0) chk({name, "_busy0"}, 32'(busy[g]), 32'd0);
         else begin
            chk({name, "_maddr"}, maddr[g], addr);
            if (c < ack_at) chk({name, "_busy"}, 32'(busy[g]), 32'd1);
         end
         if (we && c == 1) chk({name, "_mwdata"}, mwdata[g], wdata);
         if (d ? dack[g] : iack[g]) ack_c = c;
      end
      chk({name, "_ack_cycle"}, 32'(ack_c), 32'(ack_at));
      @(posedge Clk);
      #1;
      ireq[g] = 1'b0;
      dreq[g] = 1'b0;
   endtask

   initial begin
      int k;
      Reset = 1'b1;
      for (int g = 0; g < 3; g++) begin
         ireq[g] = 0; dreq[g] = 0; dwe[g] = 0;
         iaddr[g] = '0; daddr[g] = '0; dwdata[g] = '0; last_rd[g] = '0;
      end
      @(negedge Clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("reset_ctl dut%0d", g), 32'({iack[g], dack[g], mwrite[g], busy[g]}), 32'd0);
         chk($sformatf("reset_data dut%0d", g), rdata[g] | maddr[g] | mwdata[g], 32'd0);
      end
      @(posedge Clk);
      #1 Reset = 1'b0;

      // LAT=2: store, then fetch (leaves last grant = I).
      run_single(0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2, "store");
      run_single(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4, "fetch");

      // Both held: strict alternation D, I, D.
      push_exp(0, 1'b1, 1'b0, 32'h0000_0200);
      push_exp(0, 1'b0, 1'b0, 32'h0000_0080);
      push_exp(0, 1'b1, 1'b0, 32'h0000_0200);
      exp_c[0] = 4;  exp_c[1] = 9;     exp_c[2] = 14;
      exp_d[0] = 1;  exp_d[1] = 0;     exp_d[2] = 1;
      @(posedge Clk);
      #1;
      ireq[0] = 1; iaddr[0] = 32'h0000_0080;
      dreq[0] = 1; dwe[0] = 0; daddr[0] = 32'h0000_0200;
      k = 0;
      for (int c = 0; c < 24 && k < 3; c++) begin
         @(negedge Clk);
         if (iack[0] || dack[0]) begin
            chk($sformatf("tie_cycle%0d", k), 32'(c), 32'(exp_c[k]));
            chk($sformatf("tie_port%0d", k), 32'(dack[0]), 32'(exp_d[k]));
            k++;
         end
      end
      chk("tie_acks", 32'(k), 32'd3);
      @(posedge Clk);
      #1 ireq[0] = 0; dreq[0] = 0;

      // Reset during WAIT of a D load aborts it without an ack.
      @(posedge Clk);
      #1 dreq[0] = 1; dwe[0] = 0; daddr[0] = 32'h0000_0300;
      repeat (3) @(negedge Clk);
      chk("abort_busy_before", 32'(busy[0]), 32'd1);
      #1 Reset = 1'b1;
      #1;
      chk("abort_ctl", 32'({busy[0], mwrite[0], dack[0]}), 32'd0);
      dreq[0] = 0;
      last_rd[0] = '0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      repeat (6) begin
         @(negedge Clk);
         chk("abort_idle", 32'({busy[0], dack[0]}), 32'd0);
      end
      run_single(0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4, "post_reset_fetch");

      // LAT=1: back-to-back loads with DReq held.
      push_exp(1, 1'b1, 1'b0, 32'h0000_0008);
      push_exp(1, 1'b1, 1'b0, 32'h0000_0008);
      exp_c[0] = 3; exp_c[1] = 7;
      @(posedge Clk);
      #1 dreq[1] = 1; dwe[1] = 0; daddr[1] = 32'h0000_0008;
      k = 0;
      for (int c = 0; c < 16 && k < 2; c++) begin
         @(negedge Clk);
         if (dack[1]) begin
            chk($sformatf("lat1_ack_cycle%0d", k), 32'(c), 32'(exp_c[k]));
            k++;
         end
      end
      chk("lat1_acks", 32'(k), 32'd2);
      @(posedge Clk);
      #1 dreq[1] = 0;

      // LAT=15: single fetch.
      run_single(2, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 17, "lat15_fetch");

      repeat (4) @(negedge Clk);
      for (int g = 0; g < 3; g++) chk($sformatf("sb_empty dut%0d", g), 32'(sb[g].size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
